// File: rtl/song_pkg.sv
// Shared types, note pitch table and divisor helpers for the song sequencer.
package song_pkg;

  localparam int unsigned NOTE_W     = 4;
  localparam int unsigned DIV_W      = 15;
  localparam int unsigned ENTRY_W    = 3 * NOTE_W;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned NUM_DIGITS = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [NOTE_W-1:0] high;
    logic [NOTE_W-1:0] med;
    logic [NOTE_W-1:0] low;
  } note_t;

  // Middle-octave half-periods minus one at 6 MHz, digits 1..7 (C4..B4).
  localparam logic [DIV_W-1:0] MED_DIV [NUM_DIGITS] = '{
    15'd11449, 15'd10199, 15'd9086, 15'd8577, 15'd7644, 15'd6817, 15'd6072
  };

  function automatic logic digit_ok(input logic [NOTE_W-1:0] d);
    return (d != '0) && (d <= NOTE_W'(NUM_DIGITS));
  endfunction

  // Keeps a note only if exactly one field holds a legal digit; anything else is a rest.
  function automatic note_t note_clean(input note_t n);
    note_t r;
    r = '0;
    if (n.med == '0 && n.low == '0 && digit_ok(n.high)) begin
      r.high = n.high;
    end else if (n.high == '0 && n.low == '0 && digit_ok(n.med)) begin
      r.med = n.med;
    end else if (n.high == '0 && n.med == '0 && digit_ok(n.low)) begin
      r.low = n.low;
    end
    return r;
  endfunction

  // Expects a cleaned note; low doubles the middle period, high halves it.
  function automatic logic [DIV_W-1:0] note_divisor(input note_t n);
    logic [NOTE_W-1:0] digit;
    logic [2:0]        idx;
    logic [DIV_W:0]    period;
    digit = n.high | n.med | n.low;
    if (digit == '0) begin
      return '0;
    end
    idx    = 3'(digit - NOTE_W'(1));
    period = (DIV_W+1)'(MED_DIV[idx]) + (DIV_W+1)'(1);
    if (n.low != '0) begin
      return DIV_W'({period, 1'b0} - (DIV_W+2)'(1));
    end
    if (n.high != '0) begin
      return DIV_W'((period >> 1) - (DIV_W+1)'(1));
    end
    return MED_DIV[idx];
  endfunction

endpackage

// File: rtl/song_rom.sv
// Combinational song table; entries are {high, med, low} digit triples.
module song_rom
  import song_pkg::*;
#(
  parameter int unsigned SONG_LEN = 64
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [ENTRY_W-1:0] entry
);

  // Addresses at or beyond SONG_LEN read as rest.
  always_comb begin
    entry = '0;
    if (32'(addr) < SONG_LEN) begin
      case (addr)
        8'd0:    entry = 12'h010;
        8'd1:    entry = 12'h006;
        8'd2:    entry = 12'h300;
        8'd3:    entry = 12'h000;
        8'd4:    entry = 12'h030;
        8'd5:    entry = 12'h050;
        8'd6:    entry = 12'h100;
        8'd7:    entry = 12'h000;
        8'd8:    entry = 12'h005;
        8'd9:    entry = 12'h070;
        8'd10:   entry = 12'h050;
        8'd11:   entry = 12'h000;
        8'd12:   entry = 12'h200;
        8'd13:   entry = 12'h060;
        8'd14:   entry = 12'h010;
        default: entry = 12'h000;
      endcase
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Beat-paced note sequencer: walks the song ROM one entry per beat and
// presents the current note as octave digits plus a tone half-period divisor.
module song_sequencer
  import song_pkg::*;
#(
  parameter int unsigned BEAT_DIV = 1500000,
  parameter int unsigned SONG_LEN = 64,
  parameter int unsigned LOOP     = 0
) (
  input  logic              clk_6MHz,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  output logic [NOTE_W-1:0] high,
  output logic [NOTE_W-1:0] med,
  output logic [NOTE_W-1:0] low,
  output logic [DIV_W-1:0]  divisor,
  output logic              beat,
  output logic              playing,
  output logic              done
);

  localparam int unsigned       CNT_W     = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BEAT_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  note_t              note_q, note_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               beat_q, beat_d;
  logic               playing_q, playing_d;
  logic               done_q, done_d;

  logic [ENTRY_W-1:0] rom_entry;
  note_t              rom_note;
  logic               advance;

  song_rom #(.SONG_LEN(SONG_LEN)) u_rom (
    .addr  (addr_q),
    .entry (rom_entry)
  );

  assign rom_note = note_clean(note_t'(rom_entry));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    note_d  = note_q;
    div_d   = div_q;
    beat_d  = 1'b0;
    advance = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_PLAY;
          addr_d  = '0;
          cnt_d   = '0;
        end
      end
      ST_PLAY: begin
        if (start) begin
          addr_d = '0;
          cnt_d  = '0;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else begin
          advance = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (start) begin
          state_d = ST_PLAY;
          addr_d  = '0;
          cnt_d   = '0;
        end else if (!pause) begin
          state_d = ST_PLAY;
          advance = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Resume edge also counts, so a pause never shortens or stretches the beat.
    if (advance) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        beat_d = 1'b1;
        if (addr_q != ADDR_LAST) begin
          addr_d = addr_q + ADDR_W'(1);
        end else if (LOOP != 0) begin
          addr_d = '0;
        end else begin
          state_d = ST_DONE;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Fresh starts show a rest for one cycle rather than a stale address.
    case (state_d)
      ST_PLAY: begin
        if (state_q == ST_PLAY || state_q == ST_PAUSE) begin
          note_d = rom_note;
          div_d  = note_divisor(rom_note);
        end else begin
          note_d = '0;
          div_d  = '0;
        end
      end
      ST_PAUSE: div_d = '0;
      default: begin
        note_d = '0;
        div_d  = '0;
      end
    endcase

    playing_d = (state_d == ST_PLAY);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_6MHz or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      note_q    <= '0;
      div_q     <= '0;
      beat_q    <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      note_q    <= note_d;
      div_q     <= div_d;
      beat_q    <= beat_d;
      playing_q <= playing_d;
      done_q    <= done_d;
    end
  end

  assign high    = note_q.high;
  assign med     = note_q.med;
  assign low     = note_q.low;
  assign divisor = div_q;
  assign beat    = beat_q;
  assign playing = playing_q;
  assign done    = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: one stopping and one looping instance
// share stimulus; ROM is {med1, low6, high3, rest} with a 4-cycle beat.
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        pause;

  logic [3:0]  high0, med0, low0, high1, med1, low1;
  logic [14:0] div0, div1;
  logic        beat0, playing0, done0, beat1, playing1, done1;

  int n_cmp = 0;
  int n_err = 0;

  int ed[4] = '{11449, 13635, 4542, 0};
  int en[4] = '{'h010, 'h006, 'h300, 'h000};

  always #5 clk = ~clk;

  song_sequencer #(.BEAT_DIV(4), .SONG_LEN(4), .LOOP(0)) u_dut_stop (
    .clk_6MHz (clk),
    .rst      (rst),
    .start    (start),
    .pause    (pause),
    .high     (high0),
    .med      (med0),
    .low      (low0),
    .divisor  (div0),
    .beat     (beat0),
    .playing  (playing0),
    .done     (done0)
  );

  song_sequencer #(.BEAT_DIV(4), .SONG_LEN(4), .LOOP(1)) u_dut_loop (
    .clk_6MHz (clk),
    .rst      (rst),
    .start    (start),
    .pause    (pause),
    .high     (high1),
    .med      (med1),
    .low      (low1),
    .divisor  (div1),
    .beat     (beat1),
    .playing  (playing1),
    .done     (done1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] note0();
    return {20'd0, high0, med0, low0};
  endfunction

  function automatic logic [31:0] note1();
    return {20'd0, high1, med1, low1};
  endfunction

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    #2 rst = 1'b0;
    repeat (3) tick;
    check_eq("rst note", note0(), 0);
    check_eq("rst div", 32'(div0), 0);
    check_eq("rst beat", 32'(beat0), 0);
    check_eq("rst playing", 32'(playing0), 0);
    check_eq("rst done", 32'(done0), 0);
    rst = 1'b1;
    tick;
    tick;
    check_eq("idle playing", 32'(playing0), 0);
    check_eq("idle beat", 32'(beat0), 0);

    // Full song on both instances; k counts edges after the start edge.
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k <= 48; k++) begin
      int idx;
      int n0, d0, b0, p0, dn0, n1, d1, b1;
      if (k > 0) tick;
      if (k == 0) begin
        n0 = 0; d0 = 0; b0 = 0; p0 = 1; dn0 = 0;
        n1 = 0; d1 = 0; b1 = 0;
      end else begin
        if (k < 16) begin
          idx = (k - 1) / 4;
          n0 = en[idx]; d0 = ed[idx]; b0 = (k % 4 == 0) ? 1 : 0; p0 = 1; dn0 = 0;
        end else begin
          n0 = 0; d0 = 0; b0 = (k == 16) ? 1 : 0; p0 = 0; dn0 = 1;
        end
        idx = ((k - 1) / 4) % 4;
        n1 = en[idx]; d1 = ed[idx]; b1 = (k % 4 == 0) ? 1 : 0;
      end
      check_eq($sformatf("stop k=%0d note", k), note0(), 32'(n0));
      check_eq($sformatf("stop k=%0d div", k), 32'(div0), 32'(d0));
      check_eq($sformatf("stop k=%0d beat", k), 32'(beat0), 32'(b0));
      check_eq($sformatf("stop k=%0d playing", k), 32'(playing0), 32'(p0));
      check_eq($sformatf("stop k=%0d done", k), 32'(done0), 32'(dn0));
      check_eq($sformatf("loop k=%0d note", k), note1(), 32'(n1));
      check_eq($sformatf("loop k=%0d div", k), 32'(div1), 32'(d1));
      check_eq($sformatf("loop k=%0d beat", k), 32'(beat1), 32'(b1));
      check_eq($sformatf("loop k=%0d done", k), 32'(done1), 0);
    end

    // Replay from DONE.
    start = 1'b1;
    tick;
    start = 1'b0;
    check_eq("replay playing", 32'(playing0), 1);
    check_eq("replay done", 32'(done0), 0);
    check_eq("replay note e0", note0(), 0);
    tick;
    check_eq("replay note e1", note0(), 'h010);
    check_eq("replay div e1", 32'(div0), 11449);

    // Pause mid-beat for 10 sampling edges (counter holds at 1).
    pause = 1'b1;
    tick;
    check_eq("pause div", 32'(div0), 0);
    check_eq("pause note hold", note0(), 'h010);
    check_eq("pause playing", 32'(playing0), 0);
    check_eq("pause beat", 32'(beat0), 0);
    for (int i = 0; i < 9; i++) begin
      tick;
      check_eq($sformatf("paused %0d beat", i), 32'(beat0), 0);
      check_eq($sformatf("paused %0d div", i), 32'(div0), 0);
    end
    pause = 1'b0;
    tick;
    check_eq("resume beat r0", 32'(beat0), 0);
    check_eq("resume div r0", 32'(div0), 11449);
    check_eq("resume playing", 32'(playing0), 1);
    tick;
    check_eq("resume beat r1", 32'(beat0), 0);
    tick;
    check_eq("resume beat r2", 32'(beat0), 1);
    check_eq("resume note r2", note0(), 'h010);
    tick;
    check_eq("resume note r3", note0(), 'h006);
    check_eq("resume div r3", 32'(div0), 13635);
    check_eq("resume beat r3", 32'(beat0), 0);
    tick;
    check_eq("beat r4", 32'(beat0), 0);
    tick;
    check_eq("beat r5", 32'(beat0), 0);

    // Pause lands on terminal count: beat deferred to the resume edge.
    pause = 1'b1;
    tick;
    check_eq("term pause beat", 32'(beat0), 0);
    check_eq("term pause div", 32'(div0), 0);
    check_eq("term pause playing", 32'(playing0), 0);
    tick;
    check_eq("term pause beat 2", 32'(beat0), 0);
    pause = 1'b0;
    tick;
    check_eq("term resume beat", 32'(beat0), 1);
    check_eq("term resume playing", 32'(playing0), 1);
    check_eq("term resume div", 32'(div0), 13635);
    tick;
    check_eq("after term note", note0(), 'h300);
    check_eq("after term div", 32'(div0), 4542);

    // Restart at addr 2 with pause also high: start wins.
    start = 1'b1;
    pause = 1'b1;
    tick;
    start = 1'b0;
    pause = 1'b0;
    check_eq("restart playing", 32'(playing0), 1);
    check_eq("restart note s0", note0(), 'h300);
    tick;
    check_eq("restart note s1", note0(), 'h010);
    check_eq("restart div s1", 32'(div0), 11449);
    tick;
    check_eq("restart beat s2", 32'(beat0), 0);
    tick;
    check_eq("restart beat s3", 32'(beat0), 0);
    tick;
    check_eq("restart beat s4", 32'(beat0), 1);

    // Asynchronous reset between edges while beat is high.
    #3 rst = 1'b0;
    #1;
    check_eq("async rst note", note0(), 0);
    check_eq("async rst div", 32'(div0), 0);
    check_eq("async rst beat", 32'(beat0), 0);
    check_eq("async rst playing", 32'(playing0), 0);
    check_eq("async rst done", 32'(done0), 0);
    check_eq("async rst loop playing", 32'(playing1), 0);
    #1 rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      check_eq($sformatf("post rst %0d beat", i), 32'(beat0), 0);
      check_eq($sformatf("post rst %0d playing", i), 32'(playing0), 0);
      check_eq($sformatf("post rst %0d note", i), note0(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
